vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal front porch, sync width and back porch, in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical equivalents, in lines.
REQ-004 SHALL have parameters HS_POL and VS_POL, default 0: sync active level (0 = active-low).
REQ-005 SHALL have parameter CW, default 4: bits per colour channel.
REQ-006 SHALL have parameter RD_LAT, default 1, legal range 1..4: pixel RAM read latency in clocks.
REQ-007 SHALL have port clk, input, 1: pixel clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port Din, input, 3*CW: pixel in the order {B,G,R}, with R in the LSBs.
REQ-010 SHALL have ports row and col, output, 10 each: pixel RAM line and pixel address.
REQ-011 SHALL have port rdn, output, 1: pixel RAM read strobe, active-low.
REQ-012 SHALL have ports R, G and B, output, CW each: colour channels.
REQ-013 SHALL have ports HS and VS, output, 1 each: sync outputs, at the levels set by HS_POL/VS_POL.
REQ-014 SHALL have port de, output, 1: display enable, aligned with R/G/B.
REQ-015 SHALL have port frame_start, output, 1: one-cycle pulse, aligned with R/G/B.

Function
REQ-016 SHALL run h_cnt from 0 to H_TOT-1, where H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP, and wrap to 0.
REQ-017 SHALL advance v_cnt by one when h_cnt wraps, counting 0 to V_TOT-1 and wrapping to 0; V_TOT is formed the same way as H_TOT.
REQ-018 SHALL hold horizontal sync active for h_cnt < H_SYNC and vertical sync active for v_cnt < V_SYNC.
REQ-019 SHALL define the horizontal active window as H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE; the vertical window is defined the same way.
REQ-020 SHALL register row = v_cnt-(V_SYNC+V_BP), col = h_cnt-(H_SYNC+H_BP) and rdn = ~active one clock after the counter value; col is 0 on the first active pixel.
REQ-021 SHALL, while rdn is high, let row/col take the 10-bit wrapped subtraction result; the RAM ignores them.
REQ-022 SHALL sample Din RD_LAT clocks after the edge that presented the matching row/col, and register it to R/G/B on that edge.
REQ-023 SHALL delay the sync, active and frame-start terms through a shift pipeline so that HS, VS, de, frame_start and R/G/B all change on the same edge.
REQ-024 SHALL give HS/VS/R/G/B/de/frame_start a total latency of RD_LAT+1 clocks from the counter value.
REQ-025 SHALL drive R/G/B to 0 whenever the delayed de is 0.
REQ-026 SHALL pulse frame_start for the pixel derived from h_cnt=0, v_cnt=0.
REQ-027 SHALL size its counters with $clog2(H_TOT) and $clog2(V_TOT) bits, and need no further logic change for other timings.
REQ-028 SHALL stop elaboration ($error or equivalent) if RD_LAT is outside 1..4, if H_ACTIVE > 1024, or if V_ACTIVE > 1024.

Reset
REQ-029 SHALL, while rst is high, force h_cnt=0, v_cnt=0, row=0, col=0, rdn=1, R/G/B=0, de=0 and frame_start=0.
REQ-030 SHALL, while rst is high, hold HS at the inactive level ~HS_POL and VS at ~VS_POL, and clear every pipeline stage.
REQ-031 SHALL take effect immediately on assertion, including mid-line or mid-frame, without waiting for a clock edge.
REQ-032 SHALL, after release, increment h_cnt from 0 on the first rising edge and restart the frame cleanly.

Configuration
REQ-033 SHALL, when macro VGA_TESTPAT_EN is defined, add input pat_sel[1:0] after Din that replaces Din at the R/G/B stage.
REQ-034 SHALL, for pat_sel, select: 0 = Din; 1 = 8 equal vertical colour bars; 2 = 32x32 black/white checkerboard; 3 = full-scale white.
REQ-035 SHALL generate pattern pixels from delayed copies of row/col, so that patterns keep the same alignment as Din.
REQ-036 SHALL, without VGA_TESTPAT_EN, have no pat_sel port and always pass Din.

Verification
REQ-037 SHALL cover default timing: run 2 frames -> HS period 800 clocks with 96 clocks low; VS period 420000 clocks with 1600 clocks low; 640 rdn-low clocks per line over 480 lines.
REQ-038 SHALL cover address alignment: at first active pixel -> row=0 and col=0; at last active pixel -> row=479 and col=639.
REQ-039 SHALL cover RD_LAT=3 with a RAM model returning Din={col[3:0],row[3:0],col[7:4]} -> R/G/B match the addressed pixel, aligned with de and HS/VS, with zero mismatches.
REQ-040 SHALL cover async reset mid-frame at h_cnt=400, v_cnt=200 -> outputs reach reset values before the next edge; frame_start appears RD_LAT+1 clocks after the first post-release edge.
REQ-041 SHALL cover HS_POL=1 and VS_POL=1 with 800x600 timing (40/128/88, 1/4/23) -> HS high 128 of 1056 clocks, VS high 4 of 628 lines.
REQ-042 SHALL cover VGA_TESTPAT_EN with pat_sel=1 -> col 0..79 shows white (R=G=B=4'hF) and col 560..639 shows black.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel RAM read bus plus video outputs of vga_timing_gen.
// Signals: Din (pixel {B,G,R}), row/col/rdn (pixel RAM address and active-low
//   read strobe), R/G/B/HS/VS/de/frame_start (video out).
// pat_sel exists only when VGA_TESTPAT_EN is defined.
// Modports: master = timing generator, slave = RAM/display side.
interface vga_timing_gen_if #(
    parameter int CW = 4
);
    logic [3*CW-1:0] Din;
`ifdef VGA_TESTPAT_EN
    logic [1:0]      pat_sel;
`endif
    logic [9:0]      row;
    logic [9:0]      col;
    logic            rdn;
    logic [CW-1:0]   R;
    logic [CW-1:0]   G;
    logic [CW-1:0]   B;
    logic            HS;
    logic            VS;
    logic            de;
    logic            frame_start;
`ifdef VGA_TESTPAT_EN
    modport master (input Din, pat_sel, output row, col, rdn, R, G, B, HS, VS, de, frame_start);
    modport slave (output Din, pat_sel, input row, col, rdn, R, G, B, HS, VS, de, frame_start);
`else
    modport master (input Din, output row, col, rdn, R, G, B, HS, VS, de, frame_start);
    modport slave (output Din, input row, col, rdn, R, G, B, HS, VS, de, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/timing generator with a pipelined pixel RAM read path.
// Ports: clk (pixel clock, rising edge), rst (asynchronous, active-high),
//   bus (vga_timing_gen_if.master): Din in; row/col/rdn pixel RAM address out;
//   R/G/B, HS, VS, de, frame_start video out, all aligned on the same edge.
// Optional: VGA_TESTPAT_EN adds bus.pat_sel, a built-in test pattern mux on the R/G/B stage.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CW       = 4,
    parameter int RD_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW = $clog2(H_TOT);
    localparam int VW = $clog2(V_TOT);
    localparam int H_ST = H_SYNC + H_BP;
    localparam int V_ST = V_SYNC + V_BP;
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("vga_timing_gen: RD_LAT must be within 1..4");
    end
    if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_bad_size
        $error("vga_timing_gen: active area exceeds the 10-bit row/col range");
    end

    logic [HW-1:0]   h_cnt_q, h_cnt_d;
    logic [VW-1:0]   v_cnt_q, v_cnt_d;
    logic [9:0]      row_q, row_d, col_q, col_d;
    logic            rdn_q, rdn_d;
    // {frame_start, active, vsync, hsync} as active-high terms; one stage per read-latency clock
    logic [3:0]      ctl_q [RD_LAT];
    logic [3:0]      ctl_d [RD_LAT];
    logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [3*CW-1:0] rgb_q, rgb_d, pix;
    logic            act;
    int              h, v;
`ifdef VGA_TESTPAT_EN
    // {row[5], col} travels with ctl so pattern pixels land exactly where Din would
    logic [10:0]     pos_q [RD_LAT];
    logic [10:0]     pos_d [RD_LAT];
    logic [2:0]      bar;
`endif

    always_comb begin
        h = int'(h_cnt_q);
        v = int'(v_cnt_q);
        act = h >= H_ST && h < H_ST + H_ACTIVE && v >= V_ST && v < V_ST + V_ACTIVE;
        h_cnt_d = (h == H_TOT - 1) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = (h != H_TOT - 1) ? v_cnt_q : (v == V_TOT - 1) ? '0 : v_cnt_q + 1'b1;
        row_d = 10'(v - V_ST);
        col_d = 10'(h - H_ST);
        rdn_d = ~act;
        ctl_d[0] = {h == 0 && v == 0, act, v < V_SYNC, h < H_SYNC};
        for (int i = 1; i < RD_LAT; i++) ctl_d[i] = ctl_q[i-1];
        hs_d = ctl_q[RD_LAT-1][0] ? HS_ON : ~HS_ON;
        vs_d = ctl_q[RD_LAT-1][1] ? VS_ON : ~VS_ON;
        de_d = ctl_q[RD_LAT-1][2];
        fs_d = ctl_q[RD_LAT-1][3];
`ifdef VGA_TESTPAT_EN
        pos_d[0] = {row_d[5], col_d};
        for (int i = 1; i < RD_LAT; i++) pos_d[i] = pos_q[i-1];
        // bar index 0..7 across the active width; colour bits {B,G,R} = ~{bar[0], bar[2], bar[1]}
        bar = 3'(int'(pos_q[RD_LAT-1][9:0]) * 8 / H_ACTIVE);
        pix = bus.pat_sel == 2'd0 ? bus.Din :
              bus.pat_sel == 2'd1 ? {{CW{~bar[0]}}, {CW{~bar[2]}}, {CW{~bar[1]}}} :
              bus.pat_sel == 2'd2 ? {3*CW{pos_q[RD_LAT-1][10] ^ pos_q[RD_LAT-1][5]}} : '1;
`else
        pix = bus.Din;
`endif
        rgb_d = de_d ? pix : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            rdn_q   <= 1'b1;
            for (int i = 0; i < RD_LAT; i++) ctl_q[i] <= '0;
            hs_q    <= ~HS_ON;
            vs_q    <= ~VS_ON;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            rgb_q   <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rdn_q   <= rdn_d;
            for (int i = 0; i < RD_LAT; i++) ctl_q[i] <= ctl_d[i];
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            fs_q    <= fs_d;
            rgb_q   <= rgb_d;
        end
    end

`ifdef VGA_TESTPAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int i = 0; i < RD_LAT; i++) pos_q[i] <= '0;
        else for (int i = 0; i < RD_LAT; i++) pos_q[i] <= pos_d[i];
    end
`endif

    assign bus.row = row_q;
    assign bus.col = col_q;
    assign bus.rdn = rdn_q;
    assign {bus.B, bus.G, bus.R} = rgb_q;
    assign bus.HS = hs_q;
    assign bus.VS = vs_q;
    assign bus.de = de_q;
    assign bus.frame_start = fs_q;
endmodule
